point_referee: RTL and testbench



---
 rtl/pong_pkg.sv | 21 ++
 rtl/point_referee_serve_timer.sv | 33 +++
 rtl/point_referee.sv | 168 ++++++++++++++++
 tb/tb_point_referee.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong datapath types.
// Coordinates, referee states, player indices.
package pong_pkg;

  typedef logic signed [11:0] coord_t;

  typedef enum logic [1:0] {
    SERVE_WAIT,
    PLAY,
    SCORED,
    GAME_OVER
  } referee_state_t;

  localparam int PLAYER_LEFT  = 0;
  localparam int PLAYER_RIGHT = 1;

  function automatic int timer_width(input int frames);
    return (frames > 0) ? $clog2(frames + 1) : 1;
  endfunction

endpackage

// File: rtl/point_referee_serve_timer.sv
// Loadable down-counter of frame ticks.
// Holds at zero until reloaded.
module serve_timer
  import pong_pkg::*;
#(
  parameter int DELAY = 60
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic zero
);

  localparam int W = timer_width(DELAY);
  localparam logic [W-1:0] RELOAD = W'(DELAY);

  logic [W-1:0] r_cnt;

  // count down one per tick, reload on request
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RELOAD;
    end else if (load) begin
      r_cnt <= RELOAD;
    end else if (tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/point_referee.sv
// Pong point referee: edge detect, point strobes, serve timing.
// Optional match end via REFEREE_MATCH_EN.
module point_referee
  import pong_pkg::*;
#(
  parameter int HRES               = 1280,
  parameter int BALL_SIZE          = 20,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int WIN_SCORE          = 9
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        fsync,
  input  coord_t      ball_x,
  input  logic        ball_valid,
  input  logic        start,
  output logic [1:0]  increment_score,
  output logic        ball_freeze,
  output logic        serve,
  output logic        serve_dir,
  output logic        game_over
);

  localparam logic signed [12:0] HRES13 = 13'(HRES);
  localparam logic signed [12:0] SIZE13 = 13'(BALL_SIZE);

  referee_state_t r_state;
  referee_state_t w_next;

  logic [1:0] r_inc;
  logic       r_freeze;
  logic       r_serve;
  logic       r_dir;
  logic       r_go;

  logic [1:0] w_inc_d;
  logic       w_freeze_d;
  logic       w_serve_d;
  logic       w_dir_d;
  logic       w_go_d;

  logic signed [12:0] w_x13;
  logic signed [12:0] w_right;
  logic w_off_left;
  logic w_off_right;
  logic w_hit;
  logic w_zero;
  logic w_load;
  logic w_tick;
  logic w_win;
  logic w_restart;

  // widen before adding so 2047+size cannot wrap
  assign w_x13       = {ball_x[11], ball_x};
  assign w_right     = w_x13 + SIZE13;
  assign w_off_left  = ball_x[11];
  assign w_off_right = (w_right > HRES13);
  assign w_hit       = fsync && ball_valid &&
                       (w_off_left || w_off_right);

`ifdef REFEREE_MATCH_EN
  logic [3:0] r_sh_l;
  logic [3:0] r_sh_r;
  logic [3:0] w_sh_next;

  assign w_restart = (r_state == GAME_OVER) && start;
  assign w_sh_next = r_inc[PLAYER_RIGHT] ? r_sh_r + 4'd1
                                         : r_sh_l + 4'd1;
  assign w_win     = (w_sh_next == 4'(WIN_SCORE));

  // shadow scores bump as the point is handed over
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_l <= '0;
      r_sh_r <= '0;
    end else if (w_restart) begin
      r_sh_l <= '0;
      r_sh_r <= '0;
    end else if ((r_state == SCORED) && fsync) begin
      if (r_inc[PLAYER_RIGHT]) r_sh_r <= w_sh_next;
      else                     r_sh_l <= w_sh_next;
    end
  end
`else
  logic w_unused_start;
  assign w_unused_start = start;
  assign w_restart      = 1'b0;
  assign w_win          = 1'b0;
`endif

  assign w_tick = (r_state == SERVE_WAIT) && fsync;
  assign w_load = ((r_state == SCORED) && fsync) || w_restart;

  serve_timer #(
    .DELAY (SERVE_DELAY_FRAMES)
  ) u_timer (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .tick      (w_tick),
    .zero      (w_zero)
  );

  // state register
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) r_state <= SERVE_WAIT;
    else        r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SERVE_WAIT: if (fsync && w_zero) w_next = PLAY;
      PLAY:       if (w_hit) w_next = SCORED;
      SCORED:     if (fsync) w_next = w_win ? GAME_OVER
                                            : SERVE_WAIT;
      GAME_OVER:  if (w_restart) w_next = SERVE_WAIT;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    w_inc_d    = 2'b00;
    w_serve_d  = 1'b0;
    w_dir_d    = r_dir;
    w_freeze_d = (w_next != PLAY);
    w_go_d     = (w_next == GAME_OVER);
    unique case (r_state)
      SERVE_WAIT: w_serve_d = fsync && w_zero;
      PLAY: begin
        if (w_hit && w_off_left) begin
          w_inc_d[PLAYER_RIGHT] = 1'b1;
          w_dir_d = 1'(PLAYER_LEFT);
        end else if (w_hit) begin
          w_inc_d[PLAYER_LEFT] = 1'b1;
          w_dir_d = 1'(PLAYER_RIGHT);
        end
      end
      SCORED:    if (!fsync) w_inc_d = r_inc;
      GAME_OVER: if (w_restart) w_dir_d = 1'b0;
    endcase
  end

  // output registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc    <= 2'b00;
      r_freeze <= 1'b1;
      r_serve  <= 1'b0;
      r_dir    <= 1'b0;
      r_go     <= 1'b0;
    end else begin
      r_inc    <= w_inc_d;
      r_freeze <= w_freeze_d;
      r_serve  <= w_serve_d;
      r_dir    <= w_dir_d;
      r_go     <= w_go_d;
    end
  end

  assign increment_score = r_inc;
  assign ball_freeze     = r_freeze;
  assign serve           = r_serve;
  assign serve_dir       = r_dir;
  assign game_over       = r_go;

endmodule

// File: tb/tb_point_referee.sv
// Bench for point_referee: queued expected events, monitor pops.
// Match checks enabled when REFEREE_MATCH_EN is defined.
module tb_point_referee;

  logic               clk;
  logic               rst_n;
  logic               fsync;
  logic signed [11:0] ball_x;
  logic               ball_valid;
  logic               start;
  logic [1:0]         increment_score;
  logic               ball_freeze;
  logic               serve;
  logic               serve_dir;
  logic               game_over;

  point_referee #(
    .HRES               (1280),
    .BALL_SIZE          (20),
    .SERVE_DELAY_FRAMES (2),
    .WIN_SCORE          (2)
  ) dut (
    .pixel_clk       (clk),
    .rst_n           (rst_n),
    .fsync           (fsync),
    .ball_x          (ball_x),
    .ball_valid      (ball_valid),
    .start           (start),
    .increment_score (increment_score),
    .ball_freeze     (ball_freeze),
    .serve           (serve),
    .serve_dir       (serve_dir),
    .game_over       (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0 = point strobe (val = strobe bits)
  // kind 1 = serve pulse (val = {0, ball_freeze})
  typedef struct {
    bit         kind;
    logic [1:0] val;
    logic       dir;
    int         fs;
    int         len;
  } ev_t;

  ev_t exp_q[$];
  int  total;
  int  bad;
  int  fs_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic finish_ev(input ev_t a);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d val=%b dir=%b fs=%0d len=%0d",
               a.kind, a.val, a.dir, a.fs, a.len);
    end else begin
      e = exp_q.pop_front();
      if (a.kind !== e.kind || a.val !== e.val || a.dir !== e.dir ||
          a.fs != e.fs || a.len != e.len) begin
        bad++;
        $display("FAIL event got kind=%0d val=%b dir=%b fs=%0d len=%0d want kind=%0d val=%b dir=%b fs=%0d len=%0d",
                 a.kind, a.val, a.dir, a.fs, a.len,
                 e.kind, e.val, e.dir, e.fs, e.len);
      end
    end
  endtask

  task automatic monitor();
    bit  p_act;
    bit  s_act;
    ev_t cp;
    ev_t cs;
    p_act = 0;
    s_act = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) fs_cnt = 0;
      else if (fsync) fs_cnt++;
      if (increment_score != 2'b00) begin
        if (!p_act) begin
          p_act   = 1;
          cp.kind = 0;
          cp.val  = increment_score;
          cp.dir  = serve_dir;
          cp.fs   = fs_cnt;
          cp.len  = 1;
        end else cp.len++;
      end else if (p_act) begin
        p_act = 0;
        finish_ev(cp);
      end
      if (serve) begin
        if (!s_act) begin
          s_act   = 1;
          cs.kind = 1;
          cs.val  = {1'b0, ball_freeze};
          cs.dir  = serve_dir;
          cs.fs   = fs_cnt;
          cs.len  = 1;
        end else cs.len++;
      end else if (s_act) begin
        s_act = 0;
        finish_ev(cs);
      end
    end
  endtask

  task automatic push_p(input logic [1:0] v, input logic d,
                        input int fs, input int len);
    ev_t e;
    e.kind = 0; e.val = v; e.dir = d; e.fs = fs; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic push_s(input logic d, input int fs);
    ev_t e;
    e.kind = 1; e.val = 2'b00; e.dir = d; e.fs = fs; e.len = 1;
    exp_q.push_back(e);
  endtask

  // one frame: fsync for one cycle, 8 cycles total
  task automatic frame(input bit v, input int x);
    @(posedge clk); #1;
    fsync      = 1'b1;
    ball_valid = v;
    ball_x     = 12'(x);
    @(posedge clk); #1;
    fsync = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) frame(1'b1, 600);
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_inc"},    32'(increment_score), 32'h0);
    chk({tag, "_freeze"}, 32'(ball_freeze),     32'h1);
    chk({tag, "_serve"},  32'(serve),           32'h0);
    chk({tag, "_dir"},    32'(serve_dir),       32'h0);
    chk({tag, "_go"},     32'(game_over),       32'h0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    fs_cnt     = 0;
    rst_n      = 1'b0;
    fsync      = 1'b0;
    ball_valid = 1'b0;
    ball_x     = '0;
    start      = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    push_s(1'b0, 3);
    idle(3);
    frame(1'b0, -50);
    frame(1'b1, 1260);
    push_p(2'b10, 1'b0, 6, 8);
    frame(1'b1, -1);
    idle(1);
    push_s(1'b0, 10);
    idle(3);
    push_p(2'b01, 1'b1, 11, 8);
    frame(1'b1, 1261);
    frame(1'b1, -5);
    push_s(1'b1, 15);
    idle(3);
    push_p(2'b01, 1'b1, 16, 6);
    frame(1'b1, 2047);
    #1;
    rst_n = 1'b0;
    chk_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    push_s(1'b0, 3);
    idle(3);
    push_p(2'b01, 1'b1, 4, 8);
    frame(1'b1, 1261);
    idle(1);
    push_s(1'b1, 8);
    idle(3);

`ifdef REFEREE_MATCH_EN
    push_p(2'b10, 1'b0, 9, 8);
    frame(1'b1, -2048);
    idle(1);
    push_s(1'b0, 13);
    idle(3);
    push_p(2'b10, 1'b0, 14, 8);
    frame(1'b1, -1);
    idle(1);
    @(negedge clk);
    chk("go_set",    32'(game_over),   32'h1);
    chk("go_freeze", 32'(ball_freeze), 32'h1);
    idle(2);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("go_clear", 32'(game_over), 32'h0);
    push_s(1'b0, 20);
    idle(3);
`else
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(2);
    @(negedge clk);
    chk("go_tied",   32'(game_over),   32'h0);
    chk("play_free", 32'(ball_freeze), 32'h0);
`endif

    repeat (12) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
